// File: rtl/wb_master_port_pkg.sv
// Shared types and helpers for the Wishbone master port.
//   size_e  : CPU access size codes (byte/half/word; code 3 is invalid)
//   state_e : bus FSM states
//   get_width    : counter width needed to hold a value
//   is_misaligned: alignment rule for a size/offset pair
package wb_master_port_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic int unsigned get_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  // Size code 3 has no defined lane pattern, so it is rejected like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      SIZE_WORD: return |off;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wb_master_port_if.sv
// Wishbone classic single-beat bus bundle.
//   master modport: drives cyc/stb/addr/sel/data_o/we, receives data_i/ack_i
//   slave  modport: the mirror image
interface wb_master_port_if #(
  parameter int unsigned ADDR_BITS = 32
);
  logic                 wbm_cyc_o;
  logic                 wbm_stb_o;
  logic [ADDR_BITS-3:0] wbm_addr_o;
  logic [3:0]           wbm_sel_o;
  logic [31:0]          wbm_data_o;
  logic                 wbm_we_o;
  logic [31:0]          wbm_data_i;
  logic                 wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_sel_o, wbm_data_o, wbm_we_o,
    input  wbm_data_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_sel_o, wbm_data_o, wbm_we_o,
    output wbm_data_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_lane_steer.sv
// Combinational byte-lane steering for the Wishbone master port.
//   Write side: wr_size/wr_off/wdata -> sel (lane mask) + wdata_rep (replicated data)
//   Read side : rd_size/rd_off/rd_sign_ext/bus_rdata -> rdata_ext (right-aligned,
//               sign- or zero-extended load value)
// The two sides take separate size/offset inputs: the write side works on the
// request being accepted, the read side on the one latched for the bus cycle.
module wb_lane_steer
  import wb_master_port_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic        rd_sign_ext,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata_ext
);

  logic [15:0] low16;

  always_comb begin
    sel       = 4'b1111;
    wdata_rep = wdata;
    case (wr_size)
      SIZE_BYTE: begin
        sel       = 4'b0001 << wr_off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        sel       = wr_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  assign low16 = 16'(bus_rdata >> {rd_off, 3'b000});

  always_comb begin
    rdata_ext = bus_rdata;
    case (rd_size)
      SIZE_BYTE: rdata_ext = {{24{rd_sign_ext & low16[7]}}, low16[7:0]};
      SIZE_HALF: rdata_ext = {{16{rd_sign_ext & low16[15]}}, low16};
      default:   rdata_ext = bus_rdata;
    endcase
  end

endmodule

// File: rtl/wb_master_port.sv
// Wishbone initiator: turns one CPU load/store (byte/half/word) into a single
// Wishbone classic cycle, with lane steering, load extension, alignment
// checking and a no-ack timeout.
//   clk, rst             : clock and synchronous active-high reset
//   req/we/size/sign_ext/addr/wdata : CPU request, sampled only when idle
//   busy/done/err/rdata  : CPU status; done pulses one cycle, err/rdata valid with it
//   wbm                  : Wishbone master bus (see wb_master_port_if)
module wb_master_port
  import wb_master_port_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 32,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned TIMEOUT_BITS = get_width(TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          rdata,
  wb_master_port_if.master     wbm
);

  localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(TO_LAST_I);

  state_e                  state;
  logic                    cyc_q;
  logic                    we_q;
  logic [ADDR_BITS-3:0]    addr_q;
  logic [3:0]              sel_q;
  logic [31:0]             dout_q;
  logic [TIMEOUT_BITS-1:0] cnt;
  logic [1:0]              lat_size;
  logic [1:0]              lat_off;
  logic                    lat_sext;

  logic [3:0]  sel_next;
  logic [31:0] wdata_next;
  logic [31:0] rdata_ext;

  wb_lane_steer u_steer (
    .wr_size     (size),
    .wr_off      (addr[1:0]),
    .wdata       (wdata),
    .sel         (sel_next),
    .wdata_rep   (wdata_next),
    .rd_size     (lat_size),
    .rd_off      (lat_off),
    .rd_sign_ext (lat_sext),
    .bus_rdata   (wbm.wbm_data_i),
    .rdata_ext   (rdata_ext)
  );

  // done/busy are registered, so they are set on the edge that enters FIN
  // and FIN itself is the single cycle in which done is seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      dout_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      cnt      <= '0;
      lat_size <= '0;
      lat_off  <= '0;
      lat_sext <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (req) begin
            lat_size <= size;
            lat_off  <= addr[1:0];
            lat_sext <= sign_ext;
            if (is_misaligned(size, addr[1:0])) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              cyc_q  <= 1'b1;
              we_q   <= we;
              addr_q <= addr[ADDR_BITS-1:2];
              sel_q  <= sel_next;
              dout_q <= wdata_next;
              busy   <= 1'b1;
              state  <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (wbm.wbm_ack_i) begin
            if (!we_q) rdata <= rdata_ext;
            cyc_q <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b0;
            state <= ST_FIN;
          end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            cyc_q <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_FIN;
          end else begin
            cnt <= cnt + TIMEOUT_BITS'(1);
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          cyc_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wbm.wbm_cyc_o  = cyc_q;
  assign wbm.wbm_stb_o  = cyc_q;
  assign wbm.wbm_we_o   = we_q;
  assign wbm.wbm_addr_o = addr_q;
  assign wbm.wbm_sel_o  = sel_q;
  assign wbm.wbm_data_o = dout_q;

endmodule

// File: tb/tb_wb_master_port.sv
module tb_wb_master_port;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_rdata;

  // results of the most recent run_txn
  int          r_done_cyc;
  logic        r_got_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [3:0]  r_sel;
  logic [31:0] r_dout;
  logic        r_we;
  logic [29:0] r_addr;
  int          r_stb_cycles;
  int          r_extra_done;
  int          r_busy_bad;
  int          r_stb_bad;
  logic        r_addr_changed;

  wb_master_port_if #(.ADDR_BITS(32)) wbm_if ();

  wb_master_port #(.ADDR_BITS(32), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .wbm      (wbm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (byte-level rules) ----------------
  function automatic logic m_mis(input logic [1:0] s, input logic [1:0] o);
    int n;
    if (s == 2'd3) return 1'b1;
    n = 1 << s;
    return (int'(o) % n) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] s, input logic [1:0] o);
    logic [3:0] r;
    int n;
    n = 1 << s;
    for (int i = 0; i < 4; i++) r[i] = (i >= int'(o)) && (i < int'(o) + n);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] w);
    logic [31:0] r;
    int n;
    n = 1 << s;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic [1:0] o,
                                         input logic sx, input logic [31:0] bus);
    logic [31:0] r;
    int n;
    n = 1 << s;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = bus[8*(int'(o) + i) +: 8];
    if (n < 4 && sx && r[8*n-1])
      for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // ---------------- transaction driver + slave ----------------
  // ack_lat: slave raises ack this many cycles after first seeing stb (0 = never).
  // pulse_at: cycle index (after acceptance) at which to pulse an extra req; 0 = none.
  task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_sext,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [31:0] t_bus, input int ack_lat, input int pulse_at);
    int c;
    logic aligned;
    aligned = !m_mis(t_size, t_addr[1:0]);
    r_got_done = 1'b0; r_done_cyc = -1; r_err = 1'bx; r_rdata = 'x;
    r_sel = 'x; r_dout = 'x; r_we = 1'bx; r_addr = 'x;
    r_stb_cycles = 0; r_extra_done = 0; r_busy_bad = 0; r_stb_bad = 0; r_addr_changed = 1'b0;
    @(negedge clk);
    req = 1'b1; we = t_we; size = t_size; sign_ext = t_sext; addr = t_addr; wdata = t_wdata;
    @(negedge clk);
    // scramble request inputs: the DUT must work from what it latched
    req = 1'b0; we = $urandom; size = $urandom; sign_ext = $urandom; addr = $urandom; wdata = $urandom;
    c = 1;
    while (c <= 40 && !r_got_done) begin
      if (wbm_if.wbm_stb_o !== wbm_if.wbm_cyc_o) r_stb_bad++;
      if (wbm_if.wbm_stb_o === 1'b1) begin
        if (r_stb_cycles == 0) begin
          r_sel = wbm_if.wbm_sel_o; r_dout = wbm_if.wbm_data_o;
          r_we = wbm_if.wbm_we_o; r_addr = wbm_if.wbm_addr_o;
        end else if (wbm_if.wbm_addr_o !== r_addr) r_addr_changed = 1'b1;
        r_stb_cycles++;
      end
      if (done === 1'b1) begin
        r_got_done = 1'b1; r_done_cyc = c; r_err = err; r_rdata = rdata;
        if (busy !== 1'b0) r_busy_bad++;
      end else if (busy !== aligned) r_busy_bad++;
      wbm_if.wbm_ack_i = (wbm_if.wbm_stb_o === 1'b1) && (ack_lat > 0) && (r_stb_cycles == ack_lat + 1);
      wbm_if.wbm_data_i = wbm_if.wbm_ack_i ? t_bus : $urandom;
      req = (c == pulse_at);
      if (!r_got_done) begin
        @(negedge clk);
        c++;
      end
    end
    wbm_if.wbm_ack_i = 1'b0;
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) r_extra_done++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({wbm_if.wbm_cyc_o, wbm_if.wbm_stb_o, wbm_if.wbm_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_cyc_stb_we: got %b want 000", {wbm_if.wbm_cyc_o, wbm_if.wbm_stb_o, wbm_if.wbm_we_o}); end
    n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_done_err: got %b want 000", {busy, done, err}); end
    n_checks++; if (wbm_if.wbm_sel_o !== 4'b0000 || wbm_if.wbm_addr_o !== 30'd0) begin n_fail++; $display("FAIL reset_sel_addr: got sel=%b addr=%h want 0/0", wbm_if.wbm_sel_o, wbm_if.wbm_addr_o); end
    n_checks++; if (wbm_if.wbm_data_o !== 32'd0 || rdata !== 32'd0) begin n_fail++; $display("FAIL reset_data: got dout=%h rdata=%h want 0/0", wbm_if.wbm_data_o, rdata); end
    rst = 1'b0;
    model_rdata = 32'd0;
  endtask

  task automatic test_word_load;
    run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h12345678, 1, 0);
    n_checks++; if (r_addr !== 30'h40) begin n_fail++; $display("FAIL word_addr: got %h want 40", r_addr); end
    n_checks++; if (r_sel !== 4'b1111 || r_we !== 1'b0) begin n_fail++; $display("FAIL word_sel_we: got %b/%b want 1111/0", r_sel, r_we); end
    n_checks++; if (r_rdata !== 32'h12345678 || r_err !== 1'b0) begin n_fail++; $display("FAIL word_rdata: got %h err=%b want 12345678 err=0", r_rdata, r_err); end
    n_checks++; if (r_done_cyc !== 3) begin n_fail++; $display("FAIL word_latency: got %0d want 3", r_done_cyc); end
    model_rdata = 32'h12345678;
  endtask

  task automatic test_byte_load;
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80AABBCC, 1, 0);
    n_checks++; if (r_sel !== 4'b1000) begin n_fail++; $display("FAIL byte_sel: got %b want 1000", r_sel); end
    n_checks++; if (r_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_signed: got %h want ffffff80", r_rdata); end
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80AABBCC, 1, 0);
    n_checks++; if (r_rdata !== 32'h00000080) begin n_fail++; $display("FAIL byte_unsigned: got %h want 00000080", r_rdata); end
    model_rdata = 32'h00000080;
  endtask

  task automatic test_half_store;
    run_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'hDEADBEEF, 1, 0);
    n_checks++; if (r_sel !== 4'b1100 || r_we !== 1'b1) begin n_fail++; $display("FAIL half_store_sel_we: got %b/%b want 1100/1", r_sel, r_we); end
    n_checks++; if (r_dout !== 32'hABCDABCD) begin n_fail++; $display("FAIL half_store_data: got %h want abcdabcd", r_dout); end
    n_checks++; if (r_stb_cycles !== 2 || r_extra_done !== 0) begin n_fail++; $display("FAIL half_store_single_ack: got stb=%0d extra_done=%0d want 2/0", r_stb_cycles, r_extra_done); end
    n_checks++; if (r_rdata !== model_rdata) begin n_fail++; $display("FAIL half_store_rdata_hold: got %h want %h", r_rdata, model_rdata); end
  endtask

  task automatic test_misaligned;
    run_txn(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h11223344, 1, 0);
    n_checks++; if (r_stb_cycles !== 0 || r_done_cyc !== 1) begin n_fail++; $display("FAIL misaligned_timing: got stb=%0d done_cyc=%0d want 0/1", r_stb_cycles, r_done_cyc); end
    n_checks++; if (r_err !== 1'b1 || r_rdata !== model_rdata) begin n_fail++; $display("FAIL misaligned_err: got err=%b rdata=%h want 1/%h", r_err, r_rdata, model_rdata); end
    n_checks++; if (r_busy_bad !== 0) begin n_fail++; $display("FAIL misaligned_busy: got %0d bad cycles want 0", r_busy_bad); end
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h55555555, 0, 0);
    n_checks++; if (r_stb_cycles !== 8 || r_done_cyc !== 9) begin n_fail++; $display("FAIL timeout_len: got stb=%0d done_cyc=%0d want 8/9", r_stb_cycles, r_done_cyc); end
    n_checks++; if (r_err !== 1'b1 || r_rdata !== model_rdata) begin n_fail++; $display("FAIL timeout_err: got err=%b rdata=%h want 1/%h", r_err, r_rdata, model_rdata); end
    // late ack after the abort
    wbm_if.wbm_ack_i = 1'b1; wbm_if.wbm_data_i = 32'hCAFEF00D;
    @(negedge clk);
    wbm_if.wbm_ack_i = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || wbm_if.wbm_cyc_o !== 1'b0 || rdata !== model_rdata) begin n_fail++; $display("FAIL late_ack: got done=%b cyc=%b rdata=%h want 0/0/%h", done, wbm_if.wbm_cyc_o, rdata, model_rdata); end
  endtask

  task automatic test_reset_mid;
    int dones;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h300;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    n_checks++; if (wbm_if.wbm_cyc_o !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got cyc=%b busy=%b want 1/1", wbm_if.wbm_cyc_o, busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({wbm_if.wbm_cyc_o, wbm_if.wbm_stb_o, busy, done} !== 4'b0000) begin n_fail++; $display("FAIL midrst_drop: got %b want 0000", {wbm_if.wbm_cyc_o, wbm_if.wbm_stb_o, busy, done}); end
    wbm_if.wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_if.wbm_ack_i = 1'b0;
    dones = (done === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d dones want 0", dones); end
    model_rdata = 32'd0;
  endtask

  task automatic test_busy_req;
    run_txn(1'b0, 2'd1, 1'b1, 32'h402, 32'h0, 32'h9ABC1234, 3, 2);
    n_checks++; if (r_extra_done !== 0 || r_got_done !== 1'b1) begin n_fail++; $display("FAIL busy_req_one_done: got done=%b extra=%0d want 1/0", r_got_done, r_extra_done); end
    n_checks++; if (r_addr_changed !== 1'b0 || r_addr !== 30'h100) begin n_fail++; $display("FAIL busy_req_addr: got %h changed=%b want 100/0", r_addr, r_addr_changed); end
    n_checks++; if (r_rdata !== 32'hFFFF9ABC) begin n_fail++; $display("FAIL busy_req_rdata: got %h want ffff9abc", r_rdata); end
    model_rdata = 32'hFFFF9ABC;
  endtask

  task automatic test_random;
    for (int t = 0; t < 40; t++) begin
      logic        t_we, t_sx, mis;
      logic [1:0]  t_sz;
      logic [31:0] t_ad, t_wd, t_bus, exp_rd;
      int          lat;
      t_we = $urandom; t_sx = $urandom; t_sz = 2'($urandom_range(0, 3));
      t_ad = $urandom; t_wd = $urandom; t_bus = $urandom;
      lat = $urandom_range(1, 3);
      mis = m_mis(t_sz, t_ad[1:0]);
      exp_rd = (mis || t_we) ? model_rdata : m_load(t_sz, t_ad[1:0], t_sx, t_bus);
      run_txn(t_we, t_sz, t_sx, t_ad, t_wd, t_bus, lat, 0);
      n_checks++; if (r_err !== mis || r_done_cyc !== (mis ? 1 : lat + 2)) begin n_fail++; $display("FAIL rand_%0d_done: got err=%b cyc=%0d want %b/%0d", t, r_err, r_done_cyc, mis, mis ? 1 : lat + 2); end
      n_checks++; if (r_rdata !== exp_rd) begin n_fail++; $display("FAIL rand_%0d_rdata: got %h want %h", t, r_rdata, exp_rd); end
      n_checks++; if (r_busy_bad !== 0 || r_stb_bad !== 0 || r_extra_done !== 0) begin n_fail++; $display("FAIL rand_%0d_ctrl: got busy_bad=%0d stb_bad=%0d extra=%0d want 0", t, r_busy_bad, r_stb_bad, r_extra_done); end
      if (!mis) begin
        n_checks++; if (r_sel !== m_sel(t_sz, t_ad[1:0]) || r_we !== t_we || r_addr !== t_ad[31:2]) begin n_fail++; $display("FAIL rand_%0d_bus: got sel=%b we=%b addr=%h want %b/%b/%h", t, r_sel, r_we, r_addr, m_sel(t_sz, t_ad[1:0]), t_we, t_ad[31:2]); end
        n_checks++; if (r_dout !== m_wdata(t_sz, t_wd) || r_stb_cycles !== lat + 1) begin n_fail++; $display("FAIL rand_%0d_wdata: got %h stb=%0d want %h/%0d", t, r_dout, r_stb_cycles, m_wdata(t_sz, t_wd), lat + 1); end
      end else begin
        n_checks++; if (r_stb_cycles !== 0) begin n_fail++; $display("FAIL rand_%0d_mis_stb: got %0d want 0", t, r_stb_cycles); end
      end
      model_rdata = exp_rd;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = '0; wdata = '0; model_rdata = '0;
    wbm_if.wbm_ack_i = 1'b0; wbm_if.wbm_data_i = '0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_busy_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_master_port.md
Name: wb_master_port

Overview:
- Wishbone initiator that turns single-beat CPU-side load/store requests (byte/half/word) into one Wishbone master cycle.
- Sits between a core's data port and the peripheral interconnect, and drives slaves such as the board I/O block.
- Handles byte-lane steering, read sign/zero extension, alignment checking and a bus timeout, so hung or unmapped slaves cannot stall the core.

Parameters:
- ADDR_BITS, 32: width of the byte address; the bus address is [ADDR_BITS-1:2].
- TIMEOUT, 255: cycles with stb high and no ack before the cycle is aborted; 0 disables the timeout.
- TIMEOUT_BITS, GET_WIDTH(TIMEOUT): width of the timeout counter (derived).

Ports:
- clk  in  1  main clock; also clocks the bus.
- rst  in  1  synchronous reset, active-high.
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as misaligned.
- sign_ext  in  1  sign-extend load results.
- addr  in  ADDR_BITS  byte address.
- wdata  in  32  store data, right-aligned.
- busy  out  1  high from the cycle after req is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned access or timeout.
- rdata  out  32  load result, valid with done; holds its value until the next done.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe; always equal to wbm_cyc_o.
- wbm_addr_o  out  ADDR_BITS-2  word address.
- wbm_sel_o  out  4  byte lane selects.
- wbm_data_o  out  32  write data, lane-replicated.
- wbm_we_o  out  1  write enable.
- wbm_data_i  in  32  read data.
- wbm_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset: state IDLE; cyc/stb/we/busy/done/err = 0; sel = 0; addr = 0; wbm_data_o = 0; rdata = 0; timeout counter = 0. Reset mid-cycle drops cyc/stb at that edge and produces no done.
- States: IDLE, BUS, FIN. FIN is a single cycle that drives done.
- IDLE + req, aligned:
  - Latch we/size/sign_ext/addr[1:0].
  - Register the bus outputs; cyc = stb = 1; busy = 1; go to BUS.
- IDLE + req, misaligned (half with addr[0]=1; word with addr[1:0]≠0; size 3):
  - No bus cycle; go to FIN with err = 1.
- req while not IDLE is ignored; no queueing.
- BUS:
  - ack_i sampled high: capture the read result into rdata (loads only); cyc = stb = 0 at that same edge; go to FIN with err = 0.
  - No ack: counter += 1. When TIMEOUT≠0 and the counter reaches TIMEOUT: drop cyc/stb, go to FIN with err = 1; rdata is unchanged.
  - The counter clears when leaving BUS.
- FIN: done = 1 for one cycle, busy = 0 in the same cycle, return to IDLE. A new req is accepted in the cycle after done.
- Lane select (wbm_sel_o):
  - byte: 4'b0001 << addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Write data (wbm_data_o):
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Read data: shift wbm_data_i right by 8*addr[1:0], take the low 8 or 16 bits, then sign- or zero-extend per sign_ext. Word loads are passed unchanged.
- Latency with a registered-ack slave (ack one cycle after stb): req sampled at edge E0 → stb high after E0 → ack high after E1 → stb low and rdata captured at E2 → done high in the cycle after E2.
- A late ack arriving after a timeout abort is ignored, because stb is already low.

Decomposition:
- define.vh: size codes SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2; state encodings for IDLE/BUS/FIN.
- function.vh: GET_WIDTH.
- One combinational sub-module, wb_lane_steer: size/offset/wdata → sel + replicated wdata; size/offset/sign_ext/bus data → extended rdata.
- The FSM and timeout counter stay in wb_master_port.

Test Plan:
- Word load, addr 0x100, slave returns 0x12345678 with a 1-cycle ack → wbm_addr_o = 0x40, sel = 4'b1111, we = 0, rdata = 0x12345678, err = 0, done 3 cycles after req.
- Signed byte load, addr 0x103, bus data 0x80AABBCC → sel = 4'b1000, rdata = 0xFFFFFF80. Same access unsigned → rdata = 0x00000080.
- Half store, addr 0x102, wdata 0x0000ABCD → sel = 4'b1100, wbm_data_o = 0xABCDABCD, we = 1, a single ack ends the cycle.
- Half load, addr 0x101 → cyc never asserted, done with err = 1 in the cycle after req, rdata unchanged.
- TIMEOUT = 8, slave never acks → stb high exactly 8 cycles, then done with err = 1. A late ack injected afterwards → no effect.
- rst asserted while in BUS → cyc/stb/busy low the next cycle, no done. A req pulsed while busy → ignored, and exactly one done is produced.
